// File: rtl/sram_page_ledger.sv
// sram_page_ledger: per-bank ECC side store, page jump table, per-port page
// counts and a self-initialising free-page pool with a zero-bubble
// allocate/release handshake.
// Optional feature macro: SRAM_LEDGER_WATERMARK_EN adds per-port peak counts
// and a free-space low-water mark (ports wm_clr, peak_amount, min_free_space).
module sram_page_ledger #(
   parameter int NUM_PORTS = 16,
   parameter int PORT_W    = $clog2(NUM_PORTS),
   parameter int DEPTH     = 2048,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int ECC_W     = 8,
   parameter int JT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ecc_wr_en,
   input  logic [ADDR_W-1:0] ecc_wr_addr,
   input  logic [ECC_W-1:0]  ecc_din,
   input  logic              ecc_rd_en,
   input  logic [ADDR_W-1:0] ecc_rd_addr,
   output logic [ECC_W-1:0]  ecc_dout,
   input  logic              jt_wr_en,
   input  logic [ADDR_W-1:0] jt_wr_addr,
   input  logic [JT_W-1:0]   jt_din,
   input  logic              jt_rd_en,
   input  logic [ADDR_W-1:0] jt_rd_addr,
   output logic [JT_W-1:0]   jt_dout,
   output logic              ready,
   output logic              alloc_avail,
   output logic [ADDR_W-1:0] alloc_addr,
   input  logic              alloc_req,
   input  logic [PORT_W-1:0] alloc_port,
   input  logic              rel_en,
   input  logic [ADDR_W-1:0] rel_addr,
   input  logic [PORT_W-1:0] rel_port,
   input  logic [PORT_W-1:0] query_port,
   output logic [ADDR_W:0]   page_amount,
   output logic [ADDR_W:0]   free_space,
   output logic              err_underflow,
   output logic              err_overflow,
   output logic              err_port
`ifdef SRAM_LEDGER_WATERMARK_EN
   ,
   input  logic              wm_clr,
   output logic [ADDR_W:0]   peak_amount,
   output logic [ADDR_W:0]   min_free_space
`endif
);

   typedef enum logic {INIT, RUN} state_e;

   localparam logic [ADDR_W:0]   FULL_FS  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_FS   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] initCnt_q, initCnt_d;
   logic [ADDR_W-1:0] head_q, head_d;
   logic [ADDR_W-1:0] tail_q, tail_d;
   logic [ADDR_W:0]   freeSpace_q, freeSpace_d;
   logic [ADDR_W:0]   count_q [NUM_PORTS];
   logic [ADDR_W:0]   count_d [NUM_PORTS];
   logic              ready_q, ready_d;
   logic              errUnder_q, errUnder_d;
   logic              errOver_q, errOver_d;
   logic              errPort_q, errPort_d;
   logic              running, allocOk, relOk, relPortZero;

   logic [ADDR_W-1:0] pool   [DEPTH];
   logic [ECC_W-1:0]  eccMem [DEPTH];
   logic [JT_W-1:0]   jtMem  [DEPTH];
   logic [ECC_W-1:0]  eccDout_q;
   logic [JT_W-1:0]   jtDout_q;

   // Next-state for the pool pointers, free count, per-port counts and error pulses.
   always_comb begin
      running     = (state_q == RUN);
      allocOk     = running && alloc_req && (freeSpace_q != '0);
      relOk       = running && rel_en && (freeSpace_q != FULL_FS);
      relPortZero = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if ((rel_port == PORT_W'(p)) && (count_q[p] == '0)) relPortZero = 1'b1;
      end
      state_d     = state_q;
      initCnt_d   = initCnt_q;
      head_d      = head_q;
      tail_d      = tail_q;
      freeSpace_d = freeSpace_q;
      errUnder_d  = running && alloc_req && (freeSpace_q == '0);
      errOver_d   = running && rel_en && (freeSpace_q == FULL_FS);
      errPort_d   = relOk && relPortZero;
      for (int p = 0; p < NUM_PORTS; p++) begin
         count_d[p] = count_q[p]
                    + {{ADDR_W{1'b0}}, allocOk && (alloc_port == PORT_W'(p))}
                    - {{ADDR_W{1'b0}}, relOk && (rel_port == PORT_W'(p)) && (count_q[p] != '0)};
      end
      if (!running) begin
         freeSpace_d = freeSpace_q + ONE_FS;
         initCnt_d   = initCnt_q + ONE_IDX;
         if (initCnt_q == LAST_IDX) state_d = RUN;
      end else begin
         head_d      = head_q + ADDR_W'(allocOk);
         tail_d      = tail_q + ADDR_W'(relOk);
         freeSpace_d = freeSpace_q + (ADDR_W+1)'(relOk) - (ADDR_W+1)'(allocOk);
      end
      ready_d = (state_d == RUN);
   end

   // Control FSM and bookkeeping registers; reset restarts pool initialisation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= INIT;
         initCnt_q   <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         freeSpace_q <= '0;
         ready_q     <= 1'b0;
         errUnder_q  <= 1'b0;
         errOver_q   <= 1'b0;
         errPort_q   <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) count_q[p] <= '0;
      end else begin
         state_q     <= state_d;
         initCnt_q   <= initCnt_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         freeSpace_q <= freeSpace_d;
         ready_q     <= ready_d;
         errUnder_q  <= errUnder_d;
         errOver_q   <= errOver_d;
         errPort_q   <= errPort_d;
         for (int p = 0; p < NUM_PORTS; p++) count_q[p] <= count_d[p];
      end
   end

   // Free-pool storage: filled with page i at slot i during INIT, then takes releases at the tail.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == INIT) pool[initCnt_q] <= initCnt_q;
         else if (relOk)      pool[tail_q]    <= rel_addr;
      end
   end

   // ECC side-store write port, held off while in reset.
   always_ff @(posedge clk) begin
      if (rst_n && ecc_wr_en) eccMem[ecc_wr_addr] <= ecc_din;
   end

   // ECC registered read; old data on a same-address write, holds when idle.
   always_ff @(posedge clk) begin
      if (!rst_n)         eccDout_q <= '0;
      else if (ecc_rd_en) eccDout_q <= eccMem[ecc_rd_addr];
   end

   // Jump-table write port, held off while in reset.
   always_ff @(posedge clk) begin
      if (rst_n && jt_wr_en) jtMem[jt_wr_addr] <= jt_din;
   end

   // Jump-table registered read; old data on a same-address write, holds when idle.
   always_ff @(posedge clk) begin
      if (!rst_n)        jtDout_q <= '0;
      else if (jt_rd_en) jtDout_q <= jtMem[jt_rd_addr];
   end

   // Count lookup; an index with no matching port reads as zero.
   always_comb begin
      page_amount = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (query_port == PORT_W'(p)) page_amount = count_q[p];
      end
   end

   assign ecc_dout      = eccDout_q;
   assign jt_dout       = jtDout_q;
   assign ready         = ready_q;
   assign free_space    = freeSpace_q;
   assign alloc_avail   = ready_q && (freeSpace_q != '0);
   assign alloc_addr    = ready_q ? pool[head_q] : '0;
   assign err_underflow = errUnder_q;
   assign err_overflow  = errOver_q;
   assign err_port      = errPort_q;

`ifdef SRAM_LEDGER_WATERMARK_EN
   logic [ADDR_W:0] peak_q [NUM_PORTS];
   logic [ADDR_W:0] minFree_q;

   // Peak per-port count and free-space low-water mark; wm_clr rebases both to now.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) peak_q[p] <= '0;
         minFree_q <= '0;
      end else if (wm_clr) begin
         for (int p = 0; p < NUM_PORTS; p++) peak_q[p] <= count_q[p];
         minFree_q <= freeSpace_q;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (count_d[p] > peak_q[p]) peak_q[p] <= count_d[p];
         end
         if (state_q == INIT)               minFree_q <= freeSpace_d;
         else if (freeSpace_d < minFree_q) minFree_q <= freeSpace_d;
      end
   end

   // Peak lookup shares the count query index.
   always_comb begin
      peak_amount = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (query_port == PORT_W'(p)) peak_amount = peak_q[p];
      end
   end

   assign min_free_space = minFree_q;
`endif

endmodule

// File: tb/tb_sram_page_ledger.sv
// Scoreboard testbench for sram_page_ledger (default configuration).
// Stimulus pushes expectations into queues; a negedge monitor pops and
// compares whenever the DUT presents an allocation, read data, an error
// pulse, or when a status snapshot has been requested.
module tb_sram_page_ledger;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ecc_wr_en, ecc_rd_en, jt_wr_en, jt_rd_en;
   logic [10:0] ecc_wr_addr, ecc_rd_addr, jt_wr_addr, jt_rd_addr;
   logic [7:0]  ecc_din, ecc_dout;
   logic [15:0] jt_din, jt_dout;
   logic        ready, alloc_avail, alloc_req, rel_en;
   logic [10:0] alloc_addr, rel_addr;
   logic [3:0]  alloc_port, rel_port, query_port;
   logic [11:0] page_amount, free_space;
   logic        err_underflow, err_overflow, err_port;
`ifdef SRAM_LEDGER_WATERMARK_EN
   logic        wm_clr = 1'b0;
   logic [11:0] peak_amount, min_free_space;
`endif

   sram_page_ledger dut (
      .clk(clk), .rst_n(rst_n),
      .ecc_wr_en(ecc_wr_en), .ecc_wr_addr(ecc_wr_addr), .ecc_din(ecc_din),
      .ecc_rd_en(ecc_rd_en), .ecc_rd_addr(ecc_rd_addr), .ecc_dout(ecc_dout),
      .jt_wr_en(jt_wr_en), .jt_wr_addr(jt_wr_addr), .jt_din(jt_din),
      .jt_rd_en(jt_rd_en), .jt_rd_addr(jt_rd_addr), .jt_dout(jt_dout),
      .ready(ready), .alloc_avail(alloc_avail), .alloc_addr(alloc_addr),
      .alloc_req(alloc_req), .alloc_port(alloc_port),
      .rel_en(rel_en), .rel_addr(rel_addr), .rel_port(rel_port),
      .query_port(query_port), .page_amount(page_amount), .free_space(free_space),
      .err_underflow(err_underflow), .err_overflow(err_overflow), .err_port(err_port)
`ifdef SRAM_LEDGER_WATERMARK_EN
      , .wm_clr(wm_clr), .peak_amount(peak_amount), .min_free_space(min_free_space)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          fs;
      int          pa;
      int          addr;
      bit          rdy;
      bit          av;
      bit          chkAddr;
      bit          chkDout;
   } status_t;

   logic [10:0] allocQ[$];
   logic [2:0]  errQ[$];
   logic [7:0]  eccQ[$];
   logic [15:0] jtQ[$];
   status_t     statusQ[$];
   int          passCount = 0;
   int          checkCount = 0;
   logic        eccRdSeen = 1'b0;
   logic        jtRdSeen = 1'b0;
   status_t     curS;
   logic [2:0]  curErr;

   task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic noteFail(string name);
      checkCount++;
      $display("[TB] FAIL %s: DUT output with no expectation queued", name);
   endtask

   // Advance n cycles; inputs change 1 time unit after the rising edge.
   task automatic applyStimulus(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Request a status snapshot, compared by the monitor at the next falling edge.
   task automatic checkOutput(string name, int fs, int pa, int addr, bit rdy, bit av,
                              bit chkAddr, bit chkDout);
      status_t s;
      s.name = name; s.fs = fs; s.pa = pa; s.addr = addr;
      s.rdy = rdy; s.av = av; s.chkAddr = chkAddr; s.chkDout = chkDout;
      statusQ.push_back(s);
   endtask

   // Monitor: pops and compares on every DUT-presented event.
   always @(negedge clk) begin
      if (alloc_req && alloc_avail) begin
         if (allocQ.size() == 0) noteFail("alloc_addr");
         else checkVal("alloc_addr", 32'(alloc_addr), 32'(allocQ.pop_front()));
      end
      curErr = {err_underflow, err_overflow, err_port};
      if (curErr != 3'b000) begin
         if (errQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL err_pulse: got %b, expected none", curErr);
         end else checkVal("err_pulse", 32'(curErr), 32'(errQ.pop_front()));
      end
      if (eccRdSeen) begin
         if (eccQ.size() == 0) noteFail("ecc_dout");
         else checkVal("ecc_dout", 32'(ecc_dout), 32'(eccQ.pop_front()));
      end
      if (jtRdSeen) begin
         if (jtQ.size() == 0) noteFail("jt_dout");
         else checkVal("jt_dout", 32'(jt_dout), 32'(jtQ.pop_front()));
      end
      eccRdSeen = ecc_rd_en;
      jtRdSeen  = jt_rd_en;
      while (statusQ.size() > 0) begin
         curS = statusQ.pop_front();
         checkVal({curS.name, ".free_space"}, 32'(free_space), 32'(curS.fs));
         checkVal({curS.name, ".page_amount"}, 32'(page_amount), 32'(curS.pa));
         checkVal({curS.name, ".ready"}, 32'(ready), 32'(curS.rdy));
         checkVal({curS.name, ".alloc_avail"}, 32'(alloc_avail), 32'(curS.av));
         if (curS.chkAddr) checkVal({curS.name, ".alloc_addr"}, 32'(alloc_addr), 32'(curS.addr));
         if (curS.chkDout) begin
            checkVal({curS.name, ".ecc_dout"}, 32'(ecc_dout), 32'd0);
            checkVal({curS.name, ".jt_dout"}, 32'(jt_dout), 32'd0);
         end
      end
   end

   // Time limit so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $display("%0d/%0d checks passed", passCount, checkCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      ecc_wr_en = 0; ecc_rd_en = 0; jt_wr_en = 0; jt_rd_en = 0;
      ecc_wr_addr = 0; ecc_rd_addr = 0; jt_wr_addr = 0; jt_rd_addr = 0;
      ecc_din = 0; jt_din = 0;
      alloc_req = 0; alloc_port = 0; rel_en = 0; rel_addr = 0; rel_port = 0;
      query_port = 0;
      applyStimulus(3);
      checkOutput("reset", 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(1);

      // INIT: requests must be ignored silently
      rst_n = 1'b1;
      alloc_req = 1; alloc_port = 3; rel_en = 1; rel_addr = 7; rel_port = 3;
      applyStimulus(10);
      alloc_req = 0; rel_en = 0;
      applyStimulus(2037);
      checkOutput("init_last", 2047, 0, 0, 0, 0, 1, 0);
      applyStimulus(1);
      query_port = 3;
      checkOutput("ready", 2048, 0, 0, 1, 1, 1, 0);

      // ECC / jump table, including read-during-write to the same address
      ecc_wr_en = 1; ecc_wr_addr = 10; ecc_din = 8'hA5;
      jt_wr_en = 1; jt_wr_addr = 10; jt_din = 16'h1234;
      applyStimulus(1);
      ecc_din = 8'h5A; jt_din = 16'hBEEF;
      ecc_rd_en = 1; ecc_rd_addr = 10; jt_rd_en = 1; jt_rd_addr = 10;
      eccQ.push_back(8'hA5); jtQ.push_back(16'h1234);
      applyStimulus(1);
      ecc_wr_en = 0; jt_wr_en = 0;
      eccQ.push_back(8'h5A); jtQ.push_back(16'hBEEF);
      applyStimulus(1);
      ecc_rd_en = 0; jt_rd_en = 0;
      ecc_wr_en = 1; ecc_wr_addr = 20; ecc_din = 8'h11;
      applyStimulus(1);
      ecc_wr_en = 0;

      // Drain the whole pool back to back on port 3
      alloc_req = 1; alloc_port = 3;
      for (int i = 0; i < 2048; i++) begin
         allocQ.push_back(11'(i));
         applyStimulus(1);
      end
      alloc_req = 0;
      checkOutput("drained", 0, 2048, 0, 1, 0, 1, 0);
      applyStimulus(1);
      errQ.push_back(3'b100);
      alloc_req = 1;
      applyStimulus(1);
      alloc_req = 0;
      applyStimulus(1);
      checkOutput("after_underflow", 0, 2048, 0, 1, 0, 1, 0);
      applyStimulus(1);

      // Release into an empty pool, allocate it next cycle on port 7
      rel_en = 1; rel_addr = 5; rel_port = 3;
      applyStimulus(1);
      rel_en = 0;
      checkOutput("rel_into_empty", 1, 2047, 5, 1, 1, 1, 0);
      alloc_req = 1; alloc_port = 7;
      allocQ.push_back(11'd5);
      applyStimulus(1);
      alloc_req = 0;
      checkOutput("refill_p3", 0, 2047, 0, 1, 0, 0, 0);
      applyStimulus(1);
      query_port = 7;
      checkOutput("refill_p7", 0, 1, 0, 1, 0, 0, 0);
      applyStimulus(1);

      // Simultaneous alloc and release on an empty pool: underflow, release lands
      rel_en = 1; rel_addr = 9; rel_port = 3; alloc_req = 1; alloc_port = 7;
      errQ.push_back(3'b100);
      applyStimulus(1);
      rel_en = 0; alloc_req = 0;
      checkOutput("sim_empty", 1, 1, 9, 1, 1, 1, 0);
      alloc_req = 1; alloc_port = 7;
      allocQ.push_back(11'd9);
      applyStimulus(1);
      alloc_req = 0;

      // Return 101 pages on port 3 (pages 100..200)
      rel_en = 1; rel_port = 3;
      for (int i = 0; i < 101; i++) begin
         rel_addr = 11'(100 + i);
         applyStimulus(1);
      end
      rel_en = 0;
      query_port = 3;
      checkOutput("fill101", 101, 1945, 100, 1, 1, 1, 0);
      applyStimulus(1);

      // Port 2 takes one page, then same-port alloc+release at free_space 100
      alloc_req = 1; alloc_port = 2;
      allocQ.push_back(11'd100);
      applyStimulus(1);
      rel_en = 1; rel_addr = 300; rel_port = 2;
      allocQ.push_back(11'd101);
      applyStimulus(1);
      rel_en = 0; alloc_req = 0;
      query_port = 2;
      checkOutput("same_port", 100, 1, 102, 1, 1, 1, 0);
      applyStimulus(1);

      // Cross-port alloc on 2 with release on 9
      alloc_req = 1; alloc_port = 9;
      allocQ.push_back(11'd102);
      applyStimulus(1);
      alloc_port = 2; rel_en = 1; rel_addr = 302; rel_port = 9;
      allocQ.push_back(11'd103);
      applyStimulus(1);
      alloc_req = 0; rel_en = 0;
      checkOutput("cross_p2", 99, 2, 104, 1, 1, 1, 0);
      applyStimulus(1);
      query_port = 9;
      checkOutput("cross_p9", 99, 0, 0, 1, 1, 0, 0);
      applyStimulus(1);

      // Release on a port holding nothing
      rel_en = 1; rel_addr = 400; rel_port = 6;
      errQ.push_back(3'b001);
      applyStimulus(1);
      rel_en = 0;
      query_port = 6;
      checkOutput("port_err", 100, 0, 104, 1, 1, 1, 0);
      applyStimulus(1);

      // Fill to full: 1945 on port 3, 2 on port 7, 1 on port 2
      rel_en = 1; rel_port = 3;
      for (int i = 0; i < 1945; i++) begin
         rel_addr = 11'(i);
         applyStimulus(1);
      end
      rel_port = 7;
      applyStimulus(2);
      rel_port = 2;
      applyStimulus(1);
      rel_en = 0;
      query_port = 2;
      checkOutput("full", 2048, 1, 0, 1, 1, 0, 0);
      applyStimulus(1);
      rel_en = 1; rel_addr = 500; rel_port = 2;
      errQ.push_back(3'b010);
      applyStimulus(1);
      rel_en = 0;
      checkOutput("overflow_ignored", 2048, 1, 0, 1, 1, 0, 0);
      applyStimulus(1);
      query_port = 3;
      checkOutput("full_p3", 2048, 0, 0, 1, 1, 0, 0);
      applyStimulus(1);

      // Reset mid-RUN (ECC write blocked), then reset again mid-INIT
      rst_n = 0;
      ecc_wr_en = 1; ecc_wr_addr = 20; ecc_din = 8'h77;
      applyStimulus(1);
      ecc_wr_en = 0;
      checkOutput("reset_run", 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(1);
      rst_n = 1;
      applyStimulus(1000);
      rst_n = 0;
      applyStimulus(1);
      rst_n = 1;
      applyStimulus(2047);
      checkOutput("reinit_last", 2047, 0, 0, 0, 0, 1, 0);
      applyStimulus(1);
      checkOutput("reinit_ready", 2048, 0, 0, 1, 1, 1, 0);
      ecc_rd_en = 1; ecc_rd_addr = 20;
      eccQ.push_back(8'h11);
      applyStimulus(1);
      ecc_rd_en = 0;
      applyStimulus(3);

      // Every queued expectation must have been consumed
      checkVal("allocQ_left", 32'(allocQ.size()), 32'd0);
      checkVal("errQ_left", 32'(errQ.size()), 32'd0);
      checkVal("eccQ_left", 32'(eccQ.size()), 32'd0);
      checkVal("jtQ_left", 32'(jtQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/sram_page_ledger.md
# sram_page_ledger

Parametrised per-SRAM bookkeeping block for the shared packet buffer. It holds the ECC side-storage and the page jump table, and keeps per-port page counts and a free-page pool with a zero-bubble allocate/release handshake. The free pool is self-initialising after reset. It sits beside each SRAM bank, between the write-path page allocator and the read-path page recycler.

## Interface
- NUM_PORTS, 16, number of egress ports tracked
- PORT_W, 4, port index width, $clog2(NUM_PORTS)
- DEPTH, 2048, pages per SRAM
- ADDR_W, 11, page address width, $clog2(DEPTH)
- ECC_W, 8, ECC code width per page
- JT_W, 16, jump-table entry width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ecc_wr_en / ecc_wr_addr / ecc_din  in  1 / ADDR_W / ECC_W  ECC write
- ecc_rd_en / ecc_rd_addr  in  1 / ADDR_W  ECC read request
- ecc_dout  out  ECC_W  ECC read data
- jt_wr_en / jt_wr_addr / jt_din  in  1 / ADDR_W / JT_W  jump-table write
- jt_rd_en / jt_rd_addr  in  1 / ADDR_W  jump-table read request
- jt_dout  out  JT_W  jump-table read data
- ready  out  1  free pool initialised
- alloc_avail  out  1  alloc_addr valid, pool non-empty
- alloc_addr  out  ADDR_W  current head free page
- alloc_req / alloc_port  in  1 / PORT_W  consume head page, charge to port
- rel_en / rel_addr / rel_port  in  1 / ADDR_W / PORT_W  return page, credit port
- query_port  in  PORT_W  count lookup index
- page_amount  out  ADDR_W+1  pages held by query_port (combinational)
- free_space  out  ADDR_W+1  free page count
- err_underflow / err_overflow / err_port  out  1  single-cycle error pulses

## Operation
- States: INIT, RUN. Reset forces INIT with init counter 0, pool head/tail 0, all counters 0, and free_space 0.
- INIT: one pool entry is written per cycle (entry i = page i), and free_space increments each cycle. After DEPTH cycles the block goes to RUN and asserts ready. All alloc_req and rel_en are ignored in INIT, with no error pulse.
- Pool: circular buffer of DEPTH entries, ADDR_W-bit pointers that wrap naturally, first-word-fall-through. alloc_addr always shows the head. alloc_avail = ready && free_space != 0.
- Allocate: alloc_req && alloc_avail pops the head, decrements free_space and increments count[alloc_port]. alloc_req with !alloc_avail (in RUN) is ignored and pulses err_underflow.
- Release: rel_en pushes rel_addr at the tail, increments free_space and decrements count[rel_port]. If free_space == DEPTH, the release is ignored and err_overflow pulses. If count[rel_port] == 0, the push still happens, the count stays 0 and err_port pulses.
- Simultaneous allocate and release (both legal):
  - free_space is unchanged.
  - Counts move by +1 and -1 on the two ports; if alloc_port == rel_port, that count is unchanged.
  - Pop and push both occur. When the pool is empty, the allocate is an underflow; the release still lands.
- ECC and jump-table storage are simple dual-port block RAMs, no reset clear. Writes are blocked while rst_n is low.
- Read-during-write to the same address returns old data.
- page_amount = count[query_port]. An out-of-range query_port returns 0.

## Timing
- ecc_dout / jt_dout: 1-cycle latency, hold their value when the read enable is low, reset to 0.
- INIT lasts exactly DEPTH cycles after the first cycle with rst_n high. ready rises on cycle DEPTH+1.
- After a pop, the new head is valid the following cycle. Back-to-back alloc_req every cycle is sustained until the pool is empty.
- A page released in cycle N is allocatable in cycle N+1, including when the pool was empty.
- Counters and free_space update on the clock edge following the request. Error pulses are registered and last 1 cycle.
- Reset outputs: ready 0, alloc_avail 0, alloc_addr 0, free_space 0, page_amount 0, all err 0, ecc_dout 0, jt_dout 0.
- rst_n low mid-INIT or mid-RUN restarts INIT from 0 on the next cycle and discards pool contents.

## Configuration
- SRAM_LEDGER_WATERMARK_EN defined: adds a per-port peak register and a free-space low-water register.
  - peak[p] = max count[p] since reset; low-water = min free_space since ready.
  - Both read through outputs peak_amount (ADDR_W+1, indexed by query_port) and min_free_space (ADDR_W+1).
  - wm_clr (in, 1) loads both from their current values.
- Not defined: those ports and registers are absent and behaviour is otherwise identical.

## Test plan
- Reset, DEPTH=2048: ready rises at cycle 2049, free_space=2048, alloc_addr=0, all counts 0.
- 2048 back-to-back allocs on port 3: alloc_addr runs 0..2047, count[3]=2048, free_space=0, alloc_avail=0. One more alloc_req -> err_underflow pulse, no state change.
- Empty pool, rel_en page 5 port 3, then alloc_req next cycle on port 7: alloc_addr=5, count[3]=2047, count[7]=1, free_space=0.
- Same-cycle alloc port 2 and release port 2 at free_space=100: free_space stays 100, count[2] unchanged. With ports 2/9: count[2]+1, count[9]-1.
- Release on port 6 with count 0 -> err_port pulse, free_space+1, count[6]=0. Release at free_space=2048 -> err_overflow, ignored.
- rst_n low at INIT cycle 1000 -> INIT restarts; ready at 2049 cycles after release; with SRAM_LEDGER_WATERMARK_EN, peak cleared to 0.
